// File: rtl/int_to_flop_pkg.sv
// Shared flop word format, FSM encoding and payload struct for the integer-to-flop converter.
package int_to_flop_pkg;

   localparam int unsigned FLOP_W        = 13;
   localparam int unsigned FLOP_SIGN     = 12;
   localparam int unsigned FLOP_MANT_MSB = 11;
   localparam int unsigned FLOP_MANT_LSB = 4;
   localparam int unsigned FLOP_EXP_MSB  = 3;
   localparam int unsigned FLOP_EXP_LSB  = 0;
   localparam int unsigned MANT_W        = FLOP_MANT_MSB - FLOP_MANT_LSB + 1;
   localparam int unsigned EXP_W         = FLOP_EXP_MSB - FLOP_EXP_LSB + 1;
   localparam logic        FLOP_POS      = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ABS   = 3'd1,
      ST_SHIFT = 3'd2,
      ST_ROUND = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Flop word layout: {sign, mantissa, exponent}; sign=1 means non-negative.
   typedef struct packed {
      logic              sign;
      logic [MANT_W-1:0] mant;
      logic [EXP_W-1:0]  exp;
   } flop_t;

endpackage

// File: rtl/flop_round.sv
// Round-half-up of an 8-bit mantissa by its guard bit, renormalising on mantissa overflow.
module flop_round
   import int_to_flop_pkg::*;
(
   input  logic [MANT_W-1:0] mant,
   input  logic              guard,
   input  logic [EXP_W-1:0]  exp,
   output logic [MANT_W-1:0] mant_c,
   output logic [EXP_W-1:0]  exp_c
);

   logic [MANT_W:0] sum;

   // A carry out of the mantissa means the value hit 2^8; renormalise to 128 * 2^(E+1).
   always_comb begin
      sum    = {1'b0, mant} + (MANT_W+1)'(guard);
      mant_c = sum[MANT_W-1:0];
      exp_c  = exp;
      if (sum[MANT_W]) begin
         mant_c = MANT_W'(1) << (MANT_W - 1);
         exp_c  = exp + EXP_W'(1);
      end
   end

endmodule

// File: rtl/int_to_flop.sv
// Serial signed-integer to 13-bit flop converter: ABS, one right shift per cycle, round, hold.
module int_to_flop
   import int_to_flop_pkg::*;
#(
   parameter int unsigned IN_W = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic signed [IN_W-1:0] in_int,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [FLOP_W-1:0]      out_flop,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   busy
);

   state_t              state, state_nxt;
   logic [IN_W-1:0]     in_reg;
   logic [IN_W-1:0]     mag;
   logic [IN_W-1:0]     mag_abs_c;
   logic [EXP_W-1:0]    exp_r;
   logic                guard_r;
   logic                sign_r;
   flop_t               flop_r;
   logic [MANT_W-1:0]   rnd_mant_c;
   logic [EXP_W-1:0]    rnd_exp_c;
   logic                accept;
   logic                handshake;

   assign accept    = in_valid && (state == ST_IDLE);
   assign handshake = out_valid && out_ready;
   assign out_flop  = flop_r;

   // Magnitude of the captured integer; the most negative input maps to 2^(IN_W-1) unsigned.
   always_comb begin
      mag_abs_c = in_reg;
      if (in_reg[IN_W-1]) mag_abs_c = IN_W'(0) - in_reg;
   end

   flop_round u_round (
      .mant   (mag[MANT_W-1:0]),
      .guard  (guard_r),
      .exp    (exp_r),
      .mant_c (rnd_mant_c),
      .exp_c  (rnd_exp_c)
   );

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   // Next-state: shifting continues until the magnitude fits in the 8-bit mantissa.
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:  if (accept) state_nxt = ST_ABS;
         ST_ABS:   state_nxt = ((mag_abs_c >> MANT_W) != '0) ? ST_SHIFT : ST_ROUND;
         ST_SHIFT: state_nxt = ((mag >> (MANT_W + 1)) != '0) ? ST_SHIFT : ST_ROUND;
         ST_ROUND: state_nxt = ST_DONE;
         ST_DONE:  if (handshake) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Status decode of the state register.
   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b1;
      if (state == ST_IDLE) begin
         in_ready = 1'b1;
         busy     = 1'b0;
      end
   end

   // Datapath: capture, magnitude/sign, shift with guard, result load and output valid.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         in_reg    <= '0;
         mag       <= '0;
         exp_r     <= '0;
         guard_r   <= 1'b0;
         sign_r    <= FLOP_POS;
         flop_r    <= '0;
         out_valid <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (accept) in_reg <= in_int;
            end
            ST_ABS: begin
               sign_r  <= ~in_reg[IN_W-1];
               mag     <= mag_abs_c;
               exp_r   <= '0;
               guard_r <= 1'b0;
            end
            ST_SHIFT: begin
               guard_r <= mag[0];
               mag     <= mag >> 1;
               exp_r   <= exp_r + EXP_W'(1);
            end
            ST_ROUND: begin
               flop_r <= '{sign: sign_r, mant: rnd_mant_c, exp: rnd_exp_c};
            end
            ST_DONE: begin
               out_valid <= !handshake;
            end
            default: out_valid <= 1'b0;
         endcase
      end
   end

endmodule
